// File: rtl/controller_pkg.sv
// Shared definitions for the controller hotkey logic: button bit layout,
// the two recognised button combinations, and the hotkey FSM state type.
package controller_pkg;

    // Bit positions of the decoded maple bus buttons (bits 12..15 reserved)
    localparam int BTN_C     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_A     = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_D     = 11;

    // Reset combo: START+A+B+X+Y, plus D, giving the value 16'h0E0E
    localparam logic [15:0] RESET_MASK = (16'd1 << BTN_START) | (16'd1 << BTN_A) |
                                         (16'd1 << BTN_B)     | (16'd1 << BTN_X) |
                                         (16'd1 << BTN_Y)     | (16'd1 << BTN_D);

    // OSD combo: START+DOWN+LEFT = 16'h0068
    localparam logic [15:0] OSD_MASK = (16'd1 << BTN_START) | (16'd1 << BTN_DOWN) |
                                       (16'd1 << BTN_LEFT);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_RESET,
        HOLD_OSD,
        WAIT_RELEASE
    } hotkey_state_t;

    // True for the two states in which a combo hold is being timed
    function automatic logic is_hold(input hotkey_state_t s);
        return (s == HOLD_RESET) || (s == HOLD_OSD);
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Restartable clock divider. Counts 0..DIV-1 and raises tick during the
// DIV-1 cycle; clear holds the count at zero so a new interval starts clean.
module ms_tick #(
    parameter int DIV = 74_250,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tick = !clear && (count == LAST);

    // Divider counter: restart on clear, wrap after the last cycle of the interval
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/controller_hotkeys.sv
// Hotkey detector: latches controller polls, times how long an exact button
// combination is held, and emits a one-cycle reset or OSD request.
module controller_hotkeys
    import controller_pkg::*;
#(
    parameter int CLK_HZ          = 74_250_000,
    parameter int RESET_HOLD_MS   = 2000,
    parameter int OSD_HOLD_MS     = 500,
    parameter int POLL_TIMEOUT_MS = 100
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] buttons,
    input  logic        buttons_valid,
    output logic        reset_dc,
    output logic        osd_toggle,
    output logic        combo_active,
    output logic [11:0] hold_ms
);

    localparam int DIV  = CLK_HZ / 1000;
    localparam int PW   = $clog2(DIV);
    localparam int TMAX = POLL_TIMEOUT_MS * DIV;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRE_FIRE = PW'(DIV - 2);
    localparam logic [TW-1:0] TO_MAX   = TW'(TMAX);
    localparam logic [TW-1:0] TO_EDGE  = TW'(TMAX - 1);
    localparam logic [11:0]   RST_LAST = 12'(RESET_HOLD_MS - 1);
    localparam logic [11:0]   OSD_LAST = 12'(OSD_HOLD_MS - 1);

    hotkey_state_t state;
    hotkey_state_t state_next;

    logic [15:0]   btn_q;
    logic [15:0]   btn_next;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          tick;
    logic [PW-1:0] pre_cnt;
    logic          pre_clear;

    logic [15:0]   hold_mask;
    logic [11:0]   hold_last;
    logic [11:0]   hold_next;
    logic          fire_next;
    logic          reset_next;
    logic          osd_next;

    // The timeout window counts the strobe cycle itself, so btn_q drops exactly
    // TMAX cycles after the last strobe; a strobe always beats the timeout.
    assign timeout_hit = !buttons_valid && (to_cnt == TO_EDGE);
    assign btn_next    = buttons_valid ? buttons : (timeout_hit ? 16'h0000 : btn_q);

    // Poll latch and saturating poll-timeout counter
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            btn_q  <= '0;
            to_cnt <= '0;
        end else begin
            btn_q <= btn_next;
            if (buttons_valid) begin
                to_cnt <= TW'(1);
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    ms_tick #(
        .DIV (DIV),
        .CW  (PW)
    ) u_prescaler (
        .clock  (clock),
        .nreset (nreset),
        .clear  (pre_clear),
        .tick   (tick),
        .count  (pre_cnt)
    );

    // Next-state and registered-output decode. The pulse is decided one cycle
    // ahead (prescaler at DIV-2) using the value btn_q will hold next cycle, so
    // it lands exactly in the final HOLD cycle and never fires on a hold that
    // is about to be broken.
    always_comb begin
        state_next = state;
        hold_next  = '0;
        pre_clear  = 1'b1;
        fire_next  = 1'b0;
        hold_mask  = (state == HOLD_RESET) ? RESET_MASK : OSD_MASK;
        hold_last  = (state == HOLD_RESET) ? RST_LAST : OSD_LAST;

        case (state)
            IDLE: begin
                if (btn_q == RESET_MASK) begin
                    state_next = HOLD_RESET;
                end else if (btn_q == OSD_MASK) begin
                    state_next = HOLD_OSD;
                end
            end
            HOLD_RESET, HOLD_OSD: begin
                pre_clear = 1'b0;
                if (btn_q != hold_mask) begin
                    state_next = IDLE;
                end else begin
                    fire_next = (btn_next == hold_mask) && (pre_cnt == PRE_FIRE) &&
                                (hold_ms == hold_last);
                    if (tick && (hold_ms == hold_last)) begin
                        state_next = WAIT_RELEASE;
                    end else if (tick) begin
                        hold_next = (hold_ms == 12'hFFF) ? hold_ms : hold_ms + 12'd1;
                    end else begin
                        hold_next = hold_ms;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (btn_q == 16'h0000) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        reset_next = fire_next && (state == HOLD_RESET);
        osd_next   = fire_next && (state == HOLD_OSD);
    end

    // State register and registered outputs
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            hold_ms      <= '0;
            reset_dc     <= 1'b0;
            osd_toggle   <= 1'b0;
            combo_active <= 1'b0;
        end else begin
            state        <= state_next;
            hold_ms      <= hold_next;
            reset_dc     <= reset_next;
            osd_toggle   <= osd_next;
            combo_active <= is_hold(state_next);
        end
    end

endmodule

// File: tb/tb_controller_hotkeys.sv
// Self-checking bench for controller_hotkeys with DIV=10, reset hold 5 ms,
// OSD hold 3 ms and a 4 ms poll timeout.
module tb_controller_hotkeys;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] buttons = 16'h0000;
    logic        buttons_valid = 1'b0;
    logic        reset_dc;
    logic        osd_toggle;
    logic        combo_active;
    logic [11:0] hold_ms;

    controller_hotkeys #(
        .CLK_HZ          (10_000),
        .RESET_HOLD_MS   (5),
        .OSD_HOLD_MS     (3),
        .POLL_TIMEOUT_MS (4)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .reset_dc      (reset_dc),
        .osd_toggle    (osd_toggle),
        .combo_active  (combo_active),
        .hold_ms       (hold_ms)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    // One scenario: length, nreset-low cycle window, up to two expected pulse
    // cycles per output, and up to two expected HOLD windows (entry..pulse/exit)
    typedef struct {
        int len;
        int nr_lo;
        int nr_hi;
        int rst_a;
        int rst_b;
        int osd_a;
        int osd_b;
        int lo_a;
        int hi_a;
        int lo_b;
        int hi_b;
    } vec_t;

    typedef struct {
        int          scen;
        int          cyc;
        logic [15:0] val;
    } poll_t;

    localparam int NVEC = 9;

    vec_t  vecs[NVEC];
    poll_t polls[$];
    int    checks = 0;
    int    passed = 0;

    // Compare one observed value against its expected value
    task automatic check_output(input string what, input int scen, input int cyc,
                                input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s scen=%0d cycle=%0d got=%0d expected=%0d",
                     what, scen, cyc, act, exp);
        end
    endtask

    task automatic add_poll(input int s, input int c, input logic [15:0] v);
        poll_t p;
        p.scen = s;
        p.cyc  = c;
        p.val  = v;
        polls.push_back(p);
    endtask

    // Asynchronous reset with an immediate check that every output is zero
    task automatic do_reset(input int scen);
        @(posedge clock);
        #1;
        nreset        = 1'b0;
        buttons_valid = 1'b0;
        #1;
        check_output("reset_dc_rst", scen, -1, {11'd0, reset_dc}, 12'd0);
        check_output("osd_toggle_rst", scen, -1, {11'd0, osd_toggle}, 12'd0);
        check_output("combo_active_rst", scen, -1, {11'd0, combo_active}, 12'd0);
        check_output("hold_ms_rst", scen, -1, hold_ms, 12'd0);
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    // Run one table row cycle by cycle and compare all outputs every cycle
    task automatic apply_stimulus(input int s);
        for (int c = 0; c < vecs[s].len; c++) begin
            logic        in_a;
            logic        in_b;
            logic [11:0] exp_hold;
            @(posedge clock);
            #1;
            nreset        = !((c >= vecs[s].nr_lo) && (c <= vecs[s].nr_hi));
            buttons_valid = 1'b0;
            buttons       = 16'hFFFF;
            foreach (polls[i]) begin
                if ((polls[i].scen == s) && (polls[i].cyc == c)) begin
                    buttons_valid = 1'b1;
                    buttons       = polls[i].val;
                end
            end
            @(negedge clock);
            in_a     = (c >= vecs[s].lo_a) && (c <= vecs[s].hi_a);
            in_b     = (c >= vecs[s].lo_b) && (c <= vecs[s].hi_b);
            exp_hold = in_a ? 12'((c - vecs[s].lo_a) / 10) :
                       in_b ? 12'((c - vecs[s].lo_b) / 10) : 12'd0;
            check_output("reset_dc", s, c, {11'd0, reset_dc},
                         {11'd0, (c == vecs[s].rst_a) || (c == vecs[s].rst_b)});
            check_output("osd_toggle", s, c, {11'd0, osd_toggle},
                         {11'd0, (c == vecs[s].osd_a) || (c == vecs[s].osd_b)});
            check_output("combo_active", s, c, {11'd0, combo_active},
                         {11'd0, in_a || in_b});
            check_output("hold_ms", s, c, hold_ms, exp_hold);
        end
        @(posedge clock);
        #1;
        buttons_valid = 1'b0;
        nreset        = 1'b1;
    endtask

    // Reset asserted between clock edges during a hold must clear outputs at once
    task automatic async_mid_hold();
        do_reset(90);
        for (int c = 0; c <= 35; c++) begin
            @(posedge clock);
            #1;
            buttons_valid = (c == 0);
            buttons       = (c == 0) ? 16'h0E0E : 16'h0000;
            @(negedge clock);
        end
        check_output("hold_ms_before_async", 90, 35, hold_ms, 12'd3);
        check_output("combo_active_before_async", 90, 35, {11'd0, combo_active}, 12'd1);
        nreset = 1'b0;
        #1;
        check_output("combo_active_async", 90, 35, {11'd0, combo_active}, 12'd0);
        check_output("hold_ms_async", 90, 35, hold_ms, 12'd0);
        check_output("reset_dc_async", 90, 35, {11'd0, reset_dc}, 12'd0);
        repeat (2) @(posedge clock);
        #1;
        nreset        = 1'b1;
        buttons_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            check_output("reset_dc_after_async", 91, c, {11'd0, reset_dc}, 12'd0);
            check_output("combo_active_after_async", 91, c, {11'd0, combo_active}, 12'd0);
        end
    endtask

    // Hard bound on simulation time
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Build the vector table, run every row, then the hand-written sequence
    initial begin
        //          len  nr_lo nr_hi rst_a rst_b osd_a osd_b lo_a hi_a lo_b hi_b
        vecs[0] = '{160, -1, -1,  51, -1, 151, -1,  2, 51, 122, 151};  // reset combo held, then OSD
        vecs[1] = '{ 80, -1, -1,  -1, -1,  31, -1,  2, 31,  -1,  -1};  // OSD combo held
        vecs[2] = '{ 80, -1, -1,  -1, -1,  -1, -1,  2, 21,  -1,  -1};  // early release, then superset
        vecs[3] = '{ 60, -1, -1,  -1, -1,  -1, -1, -1, -1,  -1,  -1};  // superset only
        vecs[4] = '{ 90, -1, -1,  -1, -1,  31, 71,  2, 31,  42,  71};  // OSD poll once, timeout release
        vecs[5] = '{ 60, -1, -1,  -1, -1,  -1, -1,  2, 40,  -1,  -1};  // timeout breaks reset hold
        vecs[6] = '{ 90, -1, -1,  -1, -1,  -1, -1, 41, 79,  -1,  -1};  // strobe on timeout cycle
        vecs[7] = '{100, 25, 27,  91, -1,  -1, -1,  2, 24,  42,  91};  // nreset mid-hold
        vecs[8] = '{ 70, -1, -1,  -1, -1,  -1, -1,  2, 51,  -1,  -1};  // release on pulse cycle

        for (int c = 0; c <= 80; c += 20) add_poll(0, c, 16'h0E0E);
        add_poll(0, 100, 16'h0000);
        add_poll(0, 120, 16'h0068);
        add_poll(0, 140, 16'h0068);
        for (int c = 0; c <= 60; c += 20) add_poll(1, c, 16'h0068);
        add_poll(2, 0, 16'h0E0E);
        add_poll(2, 20, 16'h0000);
        add_poll(2, 40, 16'h0E0F);
        add_poll(2, 60, 16'h0E0F);
        for (int c = 0; c <= 40; c += 20) add_poll(3, c, 16'h0E0F);
        add_poll(4, 0, 16'h0068);
        add_poll(4, 40, 16'h0068);
        add_poll(5, 0, 16'h0E0E);
        add_poll(6, 0, 16'h0001);
        add_poll(6, 39, 16'h0E0E);
        for (int c = 0; c <= 80; c += 20) add_poll(7, c, 16'h0E0E);
        for (int c = 0; c <= 40; c += 20) add_poll(8, c, 16'h0E0E);
        add_poll(8, 50, 16'h0000);

        for (int s = 0; s < NVEC; s++) begin
            $display("[TB] scenario %0d", s);
            do_reset(s);
            apply_stimulus(s);
        end

        $display("[TB] asynchronous reset during hold");
        async_mid_hold();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
